// File: rtl/ln_req_arbiter.sv
// ln_req_arbiter: lets NUM_REQ softmax lanes share one in-order ln_block.
// Issue side is round-robin into a one-deep issue register. Every accepted
// sample leaves its requester index in an in-order tag FIFO, and each result
// coming back from ln_block is steered to the requester at the FIFO head.
module ln_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 8,
    parameter int DATA_W    = 16
) (
    input  logic                                 iClk,
    input  logic                                 iRst,
    input  logic [NUM_REQ-1:0]                   iReqValid,
    output logic [NUM_REQ-1:0]                   oReqReady,
    input  logic [NUM_REQ*DATA_W-1:0]            iReqData,
    output logic                                 oLnValid,
    input  logic                                 iLnReady,
    output logic [DATA_W-1:0]                    oLnData,
    input  logic                                 iLnValid,
    output logic                                 oLnReady,
    input  logic [DATA_W-1:0]                    iLnData,
    output logic [NUM_REQ-1:0]                   oRspValid,
    input  logic [NUM_REQ-1:0]                   iRspReady,
    output logic [DATA_W-1:0]                    oRspData,
    output logic [$clog2(TAG_DEPTH+1)-1:0]       oOutstanding,
    output logic                                 oErr
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    logic [TAG_W-1:0] tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [TAG_W-1:0] rr_ptr;

    logic             empty;
    logic [TAG_W-1:0] head_tag;
    logic             pop;
    logic             push;
    logic             issue_free;
    logic             can_grant;
    logic             grant_found;
    logic [TAG_W-1:0] grant_idx;
    int               cand_sum;

    assign empty        = (count == '0);
    assign head_tag     = tag_mem[rd_ptr];
    assign oOutstanding = count;

    // Return path: the head tag decides who sees the result; an empty FIFO
    // never accepts a result, so stray ln outputs cannot be misrouted.
    always_comb begin
        oRspData  = iLnData;
        oRspValid = '0;
        oLnReady  = 1'b0;
        if (!empty) begin
            oLnReady = iRspReady[head_tag];
            for (int k = 0; k < NUM_REQ; k++) begin
                oRspValid[k] = iLnValid && (head_tag == TAG_W'(k));
            end
        end
    end

    assign pop        = iLnValid && oLnReady;
    assign issue_free = !oLnValid || iLnReady;
    // A same-cycle pop frees a tag slot, so a full FIFO can still take a grant.
    assign can_grant  = issue_free && ((count != CNT_W'(TAG_DEPTH)) || pop);

    // Round-robin pick: first valid requester after the last one granted.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = 0;
        oReqReady   = '0;
        if (can_grant) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                cand_sum = int'(rr_ptr) + off;
                if (cand_sum >= NUM_REQ) begin
                    cand_sum = cand_sum - NUM_REQ;
                end
                if (!grant_found && iReqValid[cand_sum]) begin
                    grant_found = 1'b1;
                    grant_idx   = TAG_W'(cand_sum);
                end
            end
        end
        if (grant_found) begin
            oReqReady[grant_idx] = 1'b1;
        end
    end

    assign push = grant_found;

    // Issue register, round-robin pointer, tag FIFO pointers/count and sticky error.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oLnValid <= 1'b0;
            oLnData  <= '0;
            rr_ptr   <= TAG_W'(NUM_REQ - 1);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            oErr     <= 1'b0;
        end else begin
            if (push) begin
                oLnValid <= 1'b1;
                oLnData  <= iReqData[int'(grant_idx)*DATA_W +: DATA_W];
                rr_ptr   <= grant_idx;
                wr_ptr   <= wr_ptr + 1'b1;
            end else if (issue_free) begin
                oLnValid <= 1'b0;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (iLnValid && empty) begin
                oErr <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read while the count says they are live.
    always_ff @(posedge iClk) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_ln_req_arbiter.sv
// Bench for ln_req_arbiter: a behavioural stand-in for ln_block (in-order,
// fixed latency, result = input - 0x0800 so that ln(1.0) reads as 0.0),
// per-lane request queues, and a scoreboard of hand-listed expected grants.
module tb_ln_req_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;

    logic              iClk;
    logic              iRst;
    logic [NR-1:0]     iReqValid;
    logic [NR-1:0]     oReqReady;
    logic [NR*DW-1:0]  iReqData;
    logic              oLnValid;
    logic              iLnReady;
    logic [DW-1:0]     oLnData;
    logic              iLnValid;
    logic              oLnReady;
    logic [DW-1:0]     iLnData;
    logic [NR-1:0]     oRspValid;
    logic [NR-1:0]     iRspReady;
    logic [DW-1:0]     oRspData;
    logic [3:0]        oOutstanding;
    logic              oErr;

    ln_req_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(8), .DATA_W(DW)) dut (
        .iClk(iClk), .iRst(iRst),
        .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqData(iReqData),
        .oLnValid(oLnValid), .iLnReady(iLnReady), .oLnData(oLnData),
        .iLnValid(iLnValid), .oLnReady(oLnReady), .iLnData(iLnData),
        .oRspValid(oRspValid), .iRspReady(iRspReady), .oRspData(oRspData),
        .oOutstanding(oOutstanding), .oErr(oErr)
    );

    typedef struct {
        logic [NR-1:0] onehot;
        logic [DW-1:0] data;
        logic [DW-1:0] rsp;
    } exp_t;

    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ln_ent_t;

    typedef struct {
        logic [NR-1:0] onehot;
        logic [DW-1:0] data;
    } rsp_t;

    exp_t          exp_grant[$];
    logic [DW-1:0] exp_ln[$];
    rsp_t          exp_rsp[$];
    ln_ent_t       ln_q[$];
    logic [DW-1:0] req_q[NR][$];
    logic          err_force;

    int n_cmp = 0;
    int n_err = 0;

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got an unexpected transfer required none", name);
    endtask

    // Requester and ln_block stand-in: capture handshakes at negedge, update after posedge.
    initial begin
        logic [NR-1:0] acc;
        logic          in_fire;
        logic          out_fire;
        logic [DW-1:0] in_d;
        int            cyc;
        cyc       = 0;
        iReqValid = '0;
        iReqData  = '0;
        iLnValid  = 1'b0;
        iLnData   = '0;
        forever begin
            @(negedge iClk);
            acc      = iRst ? '0 : (iReqValid & oReqReady);
            in_fire  = !iRst && oLnValid && iLnReady;
            in_d     = oLnData;
            out_fire = !iRst && iLnValid && oLnReady;
            @(posedge iClk);
            #1;
            cyc++;
            for (int k = 0; k < NR; k++) begin
                if (acc[k] && req_q[k].size() > 0) void'(req_q[k].pop_front());
            end
            if (out_fire && ln_q.size() > 0) void'(ln_q.pop_front());
            if (in_fire) ln_q.push_back('{d: in_d, t: cyc});
            for (int k = 0; k < NR; k++) begin
                iReqValid[k] = (req_q[k].size() > 0);
                iReqData[k*DW +: DW] = (req_q[k].size() > 0) ? req_q[k][0] : '0;
            end
            iLnValid = err_force || (ln_q.size() > 0 && cyc >= ln_q[0].t + 3);
            iLnData  = (ln_q.size() > 0) ? (ln_q[0].d - 16'h0800) : '0;
        end
    end

    // Scoreboard monitor: every grant, issue and response transfer is checked in order.
    initial begin
        exp_t e;
        rsp_t r;
        forever begin
            @(negedge iClk);
            if (!iRst) begin
                if (oLnValid && iLnReady) begin
                    if (exp_ln.size() == 0) unexpected("ln_issue");
                    else check("ln_issue_data", 32'(oLnData), 32'(exp_ln.pop_front()));
                end
                if (iLnValid && oLnReady) begin
                    if (exp_rsp.size() == 0) unexpected("rsp");
                    else begin
                        r = exp_rsp.pop_front();
                        check("rsp_valid", 32'(oRspValid), 32'(r.onehot));
                        check("rsp_data", 32'(oRspData), 32'(r.data));
                    end
                end
                if (oReqReady != '0) begin
                    if (exp_grant.size() == 0) unexpected("grant");
                    else begin
                        e = exp_grant.pop_front();
                        check("grant", 32'(oReqReady), 32'(e.onehot));
                        exp_ln.push_back(e.data);
                        exp_rsp.push_back('{onehot: e.onehot, data: e.rsp});
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge iClk);
        #2;
    endtask

    task automatic req(input int k, input logic [DW-1:0] d);
        req_q[k].push_back(d);
    endtask

    task automatic exp_g(input int k, input logic [DW-1:0] d, input logic [DW-1:0] rsp);
        exp_grant.push_back('{onehot: NR'(1) << k, data: d, rsp: rsp});
    endtask

    task automatic flush();
        exp_grant.delete();
        exp_ln.delete();
        exp_rsp.delete();
        ln_q.delete();
        for (int k = 0; k < NR; k++) req_q[k].delete();
    endtask

    task automatic do_reset();
        step(1);
        iRst = 1'b1;
        step(1);
        flush();
        step(2);
        iRst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            step(1);
            idle = (exp_grant.size() == 0) && (exp_ln.size() == 0) && (exp_rsp.size() == 0)
                && (ln_q.size() == 0) && (oOutstanding == 0) && (req_q[0].size() == 0)
                && (req_q[1].size() == 0) && (req_q[2].size() == 0) && (req_q[3].size() == 0);
        end
        n_cmp++;
        if (!idle) begin
            n_err++;
            $display("FAIL %s_drain: got pending work after 300 cycles required idle", name);
        end
        check({name, "_outstanding"}, 32'(oOutstanding), 32'd0);
    endtask

    initial begin
        iRst      = 1'b1;
        iLnReady  = 1'b1;
        iRspReady = '1;
        err_force = 1'b0;
        step(3);
        check("rst_ln_valid", 32'(oLnValid), 0);
        check("rst_ln_data", 32'(oLnData), 0);
        check("rst_outstanding", 32'(oOutstanding), 0);
        check("rst_err", 32'(oErr), 0);
        check("rst_ln_ready", 32'(oLnReady), 0);
        iRst = 1'b0;
        step(1);
        check("post_rst_rsp_valid", 32'(oRspValid), 0);

        // Single requester: 1.0 in, ln = 0.0 back on lane 1.
        exp_g(1, 16'h0800, 16'h0000);
        req(1, 16'h0800);
        wait_idle("single");

        // Round-robin with all lanes streaming.
        do_reset();
        exp_g(0, 16'h1000, 16'h0800); exp_g(1, 16'h1100, 16'h0900);
        exp_g(2, 16'h1200, 16'h0A00); exp_g(3, 16'h1300, 16'h0B00);
        exp_g(0, 16'h1001, 16'h0801); exp_g(1, 16'h1101, 16'h0901);
        exp_g(2, 16'h1201, 16'h0A01); exp_g(3, 16'h1301, 16'h0B01);
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < NR; k++) req(k, 16'h1000 + 16'(k * 256) + 16'(j));
        wait_idle("rr");

        // Full stall: eight tags in flight, then a pop lets exactly one grant through.
        do_reset();
        iRspReady = '0;
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < NR; k++) begin
                exp_g(k, 16'h2000 + 16'(k * 256) + 16'(j), 16'h1800 + 16'(k * 256) + 16'(j));
                req(k, 16'h2000 + 16'(k * 256) + 16'(j));
            end
        step(20);
        check("full_outstanding", 32'(oOutstanding), 8);
        @(negedge iClk);
        check("full_no_grant", 32'(oReqReady), 0);
        step(1);
        iRspReady = 4'b0001;
        @(negedge iClk);
        check("full_pop_ready", 32'(oLnReady), 1);
        check("full_pop_grant", 32'(oReqReady), 32'b0001);
        step(1);
        check("full_count_held", 32'(oOutstanding), 8);
        @(negedge iClk);
        check("full_hol_grant", 32'(oReqReady), 0);
        check("full_hol_ready", 32'(oLnReady), 0);
        step(1);
        iRspReady = '1;
        wait_idle("full");

        // Head-of-line: lane 2 at the head and stalled blocks lane 0.
        do_reset();
        iRspReady = 4'b1011;
        exp_g(2, 16'h3000, 16'h2800);
        exp_g(0, 16'h3100, 16'h2900);
        req(2, 16'h3000);
        step(1);
        req(0, 16'h3100);
        step(10);
        @(negedge iClk);
        check("hol_rsp_valid", 32'(oRspValid), 32'b0100);
        check("hol_ln_ready", 32'(oLnReady), 0);
        check("hol_rsp_data", 32'(oRspData), 32'h2800);
        check("hol_outstanding", 32'(oOutstanding), 2);
        step(4);
        @(negedge iClk);
        check("hol_rsp_valid_held", 32'(oRspValid), 32'b0100);
        step(1);
        iRspReady = '1;
        wait_idle("hol");

        // Issue backpressure: data held, no grants, resume after the last granted lane.
        do_reset();
        iLnReady = 1'b0;
        exp_g(1, 16'h4000, 16'h3800);
        exp_g(3, 16'h4300, 16'h3B00);
        exp_g(1, 16'h4001, 16'h3801);
        req(1, 16'h4000);
        req(1, 16'h4001);
        req(3, 16'h4300);
        step(6);
        @(negedge iClk);
        check("bp_ln_valid", 32'(oLnValid), 1);
        check("bp_ln_data", 32'(oLnData), 32'h4000);
        check("bp_no_grant", 32'(oReqReady), 0);
        check("bp_outstanding", 32'(oOutstanding), 1);
        step(1);
        check("bp_ln_data_stable", 32'(oLnData), 32'h4000);
        iLnReady = 1'b1;
        @(negedge iClk);
        check("bp_resume_grant", 32'(oReqReady), 32'b1000);
        step(1);
        wait_idle("bp");

        // Protocol error: a result with nothing outstanding.
        check("err_before", 32'(oErr), 0);
        err_force = 1'b1;
        step(1);
        err_force = 1'b0;
        @(negedge iClk);
        check("err_ln_ready", 32'(oLnReady), 0);
        check("err_rsp_valid", 32'(oRspValid), 0);
        check("err_not_yet", 32'(oErr), 0);
        step(1);
        check("err_set", 32'(oErr), 1);
        step(5);
        check("err_sticky", 32'(oErr), 1);

        // Asynchronous reset in the middle of traffic.
        iRspReady = '0;
        exp_g(0, 16'h5000, 16'h4800);
        exp_g(0, 16'h5001, 16'h4801);
        exp_g(0, 16'h5002, 16'h4802);
        req(0, 16'h5000); req(0, 16'h5001); req(0, 16'h5002);
        step(8);
        check("mid_outstanding", 32'(oOutstanding), 3);
        check("mid_ln_data", 32'(oLnData), 32'h5002);
        @(posedge iClk);
        #3;
        iRst = 1'b1;
        #1;
        check("arst_ln_valid", 32'(oLnValid), 0);
        check("arst_ln_data", 32'(oLnData), 0);
        check("arst_outstanding", 32'(oOutstanding), 0);
        check("arst_err", 32'(oErr), 0);
        check("arst_rsp_valid", 32'(oRspValid), 0);
        check("arst_ln_ready", 32'(oLnReady), 0);
        step(1);
        flush();
        step(2);
        iRst = 1'b0;
        iRspReady = '1;
        step(3);
        check("post_arst_err", 32'(oErr), 0);
        check("post_arst_outstanding", 32'(oOutstanding), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
